// File: rtl/sys_defs.sv
// Shared core definitions: functional-unit and CDB counts, ROB tag width,
// and the packets that travel between reservation stations, units and CDBs.
package sys_defs;

    localparam int XLEN      = 32;
    localparam int NUM_FU    = 4;
    localparam int NUM_CDB   = 2;
    localparam int ROB_TAG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
    } CDB_PACKET;

    // Issue packet from a reservation station; the ROB tag rides along so the
    // unit can return it with its result.
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      opa;
        logic [XLEN-1:0]      opb;
    } FU_RS_PACKET;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: one-hot grant for the first request at or after ptr,
// wrapping past the top index. ptr must be below N.
module rr_select #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);
    import sys_defs::*;

    logic [N-1:0] rot;
    logic [N-1:0] iso;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign rot = N'({req, req} >> ptr);
    assign iso = rot & (-rot);
    assign gnt = N'(({iso, iso} << ptr) >> N);

endmodule

// File: rtl/cdb_arbiter.sv
// Per-unit holding registers feeding NUM_CDB broadcast slots. Grants come only
// from registered state, so fu_* inputs never reach an output combinationally.
module cdb_arbiter #(
    parameter int NUM_FU  = sys_defs::NUM_FU,
    parameter int NUM_CDB = sys_defs::NUM_CDB,
    parameter int TAG_W   = sys_defs::ROB_TAG_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]          fu_tag,
    input  logic [NUM_FU*sys_defs::XLEN-1:0] fu_value,
    input  logic [NUM_FU-1:0]                fu_take_branch,
    output logic [NUM_FU-1:0]                fu_ready,
    output logic [NUM_CDB-1:0]               cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]         cdb_tag,
    output logic [NUM_CDB*sys_defs::XLEN-1:0] cdb_value,
    output logic [NUM_CDB-1:0]               cdb_take_branch
);
    import sys_defs::*;

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic             take_branch;
    } slot_t;

    logic [NUM_FU-1:0] hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]  hold_tag_q   [NUM_FU];
    logic [TAG_W-1:0]  hold_tag_d   [NUM_FU];
    logic [XLEN-1:0]   hold_value_q [NUM_FU];
    logic [XLEN-1:0]   hold_value_d [NUM_FU];
    logic [NUM_FU-1:0] hold_tb_q, hold_tb_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0] slot_gnt [NUM_CDB];
    logic [NUM_FU-1:0] taken    [NUM_CDB+1];
    logic [NUM_FU-1:0] grant;

    assign taken[0] = '0;
    assign grant    = taken[NUM_CDB];
    assign fu_ready = ~hold_valid_q | grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CDB; gi++) begin : g_slot
            slot_t pkt;

            // Each slot only sees the units not already claimed by lower slots.
            rr_select #(.N(NUM_FU), .PTR_W(PTR_W)) u_sel (
                .req (hold_valid_q & ~taken[gi]),
                .ptr (rr_ptr_q),
                .gnt (slot_gnt[gi])
            );
            assign taken[gi+1] = taken[gi] | slot_gnt[gi];

            always_comb begin
                pkt = '0;
                for (int i = 0; i < NUM_FU; i++) begin
                    if (slot_gnt[gi][i]) begin
                        pkt.valid       = 1'b1;
                        pkt.tag         = hold_tag_q[i];
                        pkt.value       = hold_value_q[i];
                        pkt.take_branch = hold_tb_q[i];
                    end
                end
            end

            assign cdb_valid[gi]                 = pkt.valid;
            assign cdb_tag[gi*TAG_W +: TAG_W]    = pkt.tag;
            assign cdb_value[gi*XLEN +: XLEN]    = pkt.value;
            assign cdb_take_branch[gi]           = pkt.take_branch;
        end
    endgenerate

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_value_d = hold_value_q;
        hold_tb_d    = hold_tb_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (squash) begin
                hold_valid_d[i] = 1'b0;
            end else if (fu_valid[i] && fu_ready[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
                hold_value_d[i] = fu_value[i*XLEN +: XLEN];
                hold_tb_d[i]    = fu_take_branch[i];
            end else if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    // Later slots overwrite earlier ones, leaving the last grant in scan order.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_CDB; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (slot_gnt[k][i]) begin
                    rr_ptr_d = PTR_W'(wrap_inc(i, NUM_FU));
                end
            end
        end
        if (squash) begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        hold_tag_q   <= hold_tag_d;
        hold_value_q <= hold_value_d;
        hold_tb_q    <= hold_tb_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a table of per-cycle vectors with hand-derived
// expectations, then a saturated-traffic run tracked by per-unit scoreboards.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int NC = 2;
    localparam int TW = 6;
    localparam int XW = 32;
    localparam int NV = 24;

    logic             clock = 1'b0;
    logic             reset;
    logic             squash;
    logic [NF-1:0]    fu_valid;
    logic [NF*TW-1:0] fu_tag;
    logic [NF*XW-1:0] fu_value;
    logic [NF-1:0]    fu_take_branch;
    logic [NF-1:0]    fu_ready;
    logic [NC-1:0]    cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*XW-1:0] cdb_value;
    logic [NC-1:0]    cdb_take_branch;

    cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC), .TAG_W(TW)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (fu_valid),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_take_branch  (fu_take_branch),
        .fu_ready        (fu_ready),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_take_branch (cdb_take_branch)
    );

    always #5 clock = ~clock;

    // Inputs applied before an edge, and the outputs expected in the cycle after it.
    typedef struct {
        logic        rst;
        logic        sq;
        logic [3:0]  fv;
        logic [23:0] tg;
        logic [3:0]  rdy;
        logic [1:0]  cv;
        logic [5:0]  t0;
        logic [5:0]  t1;
    } vec_t;

    vec_t vecs [NV];
    vec_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [5:0] sb_tag [NF][$];
    int         sb_cap [NF][$];
    logic [3:0] seq    [NF];

    function automatic logic [31:0] val_of(input logic [5:0] t);
        return 32'h0000_1234 + ({26'd0, t} - 32'd5) * 32'h0001_0003;
    endfunction

    function automatic vec_t mk(input logic rst, input logic sq, input logic [3:0] fv,
                                input logic [5:0] u0, input logic [5:0] u1,
                                input logic [5:0] u2, input logic [5:0] u3,
                                input logic [3:0] rdy, input logic [1:0] cv,
                                input logic [5:0] t0, input logic [5:0] t1);
        vec_t v;
        v.rst = rst; v.sq = sq; v.fv = fv;
        v.tg  = {u3, u2, u1, u0};
        v.rdy = rdy; v.cv = cv; v.t0 = t0; v.t1 = t1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        reset    = v.rst;
        squash   = v.sq;
        fu_valid = v.fv;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i*TW +: TW]   = v.tg[i*TW +: TW];
            fu_value[i*XW +: XW] = val_of(v.tg[i*TW +: TW]);
            fu_take_branch[i]    = v.tg[i*TW];
        end
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        logic [5:0] et;
        $display("vec %0d: ready=%b cdb_valid=%b tag0=%0d tag1=%0d", idx, fu_ready,
                 cdb_valid, cdb_tag[5:0], cdb_tag[11:6]);
        chk($sformatf("v%0d_ready", idx), 32'(fu_ready), 32'(v.rdy));
        chk($sformatf("v%0d_cdb_valid", idx), 32'(cdb_valid), 32'(v.cv));
        for (int k = 0; k < NC; k++) begin
            et = (k == 0) ? v.t0 : v.t1;
            chk($sformatf("v%0d_slot%0d_tag", idx, k), 32'(cdb_tag[k*TW +: TW]), 32'(et));
            chk($sformatf("v%0d_slot%0d_value", idx, k), cdb_value[k*XW +: XW],
                v.cv[k] ? val_of(et) : 32'd0);
            chk($sformatf("v%0d_slot%0d_tb", idx, k), 32'(cdb_take_branch[k]),
                v.cv[k] ? 32'(et[0]) : 32'd0);
        end
    endtask

    initial begin
        logic [5:0] t;
        logic [5:0] et;
        int         u;
        int         ec;
        vec_t       v;

        reset = 1'b1; squash = 1'b0; fu_valid = '0;
        fu_tag = '0; fu_value = '0; fu_take_branch = '0;

        //            rst   sq    fv       u0    u1    u2    u3     rdy     cv     t0    t1
        vecs[0]  = mk(1'b1, 1'b0, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[1]  = mk(1'b1, 1'b0, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[3]  = mk(1'b0, 1'b0, 4'b0100, 6'd0, 6'd0, 6'd5, 6'd0,  4'b1111, 2'b01, 6'd5, 6'd0);
        vecs[4]  = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[5]  = mk(1'b0, 1'b0, 4'b1001, 6'd7, 6'd0, 6'd0, 6'd8,  4'b1111, 2'b11, 6'd8, 6'd7);
        vecs[6]  = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[7]  = mk(1'b0, 1'b0, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd9,  4'b1111, 2'b01, 6'd9, 6'd0);
        vecs[8]  = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[9]  = mk(1'b0, 1'b0, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4,  4'b0011, 2'b11, 6'd1, 6'd2);
        vecs[10] = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b11, 6'd3, 6'd4);
        vecs[11] = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[12] = mk(1'b0, 1'b0, 4'b0001, 6'd10, 6'd0, 6'd0, 6'd0, 4'b1111, 2'b01, 6'd10, 6'd0);
        vecs[13] = mk(1'b0, 1'b0, 4'b0001, 6'd11, 6'd0, 6'd0, 6'd0, 4'b1111, 2'b01, 6'd11, 6'd0);
        vecs[14] = mk(1'b0, 1'b0, 4'b0001, 6'd12, 6'd0, 6'd0, 6'd0, 4'b1111, 2'b01, 6'd12, 6'd0);
        vecs[15] = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[16] = mk(1'b0, 1'b0, 4'b0111, 6'd19, 6'd20, 6'd21, 6'd0, 4'b1110, 2'b11, 6'd20, 6'd21);
        vecs[17] = mk(1'b0, 1'b1, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd22, 4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[18] = mk(1'b0, 1'b0, 4'b0011, 6'd23, 6'd24, 6'd0, 6'd0, 4'b1111, 2'b11, 6'd24, 6'd23);
        vecs[19] = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[20] = mk(1'b0, 1'b0, 4'b1111, 6'd25, 6'd26, 6'd27, 6'd28, 4'b0110, 2'b11, 6'd26, 6'd27);
        vecs[21] = mk(1'b1, 1'b1, 4'b1111, 6'd29, 6'd30, 6'd31, 6'd32, 4'b1111, 2'b00, 6'd0, 6'd0);
        vecs[22] = mk(1'b0, 1'b0, 4'b1001, 6'd33, 6'd0, 6'd0, 6'd34, 4'b1111, 2'b11, 6'd33, 6'd34);
        vecs[23] = mk(1'b0, 1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0,  4'b1111, 2'b00, 6'd0, 6'd0);

        for (int j = 0; j < NV; j++) begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                check_vec(v, j - 1);
            end
            drive_vec(vecs[j]);
            exp_q.push_back(vecs[j]);
        end
        @(negedge clock);
        v = exp_q.pop_front();
        check_vec(v, NV - 1);

        // Saturated traffic: every unit presents continuously, holding its result
        // until accepted; each accepted tag must come out in order within 2 cycles.
        for (int i = 0; i < NF; i++) seq[i] = 4'd0;
        for (int it = 0; it < 20; it++) begin
            @(negedge clock);
            for (int k = 0; k < NC; k++) begin
                if (cdb_valid[k]) begin
                    t = cdb_tag[k*TW +: TW];
                    u = int'(t[5:4]);
                    $display("hs cycle %0d: slot %0d broadcasts unit %0d tag 0x%0h", it, k, u, t);
                    if (sb_tag[u].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL hs_unexpected: actual tag=0x%0h required=none pending", t);
                    end else begin
                        et = sb_tag[u].pop_front();
                        ec = sb_cap[u].pop_front();
                        chk($sformatf("hs%0d_tag", it), 32'(t), 32'(et));
                        chk($sformatf("hs%0d_value", it), cdb_value[k*XW +: XW], val_of(et));
                        chk($sformatf("hs%0d_tb", it), 32'(cdb_take_branch[k]), 32'(et[0]));
                        chk($sformatf("hs%0d_age_ok", it),
                            32'((it - ec >= 1) && (it - ec <= 2)), 32'd1);
                    end
                end
            end
            if (it >= 1 && it <= 12) begin
                chk($sformatf("hs%0d_full", it), 32'(cdb_valid), 32'(2'b11));
            end
            reset  = 1'b0;
            squash = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (it < 12) begin
                    t = {2'(i), seq[i]};
                    fu_valid[i]          = 1'b1;
                    fu_tag[i*TW +: TW]   = t;
                    fu_value[i*XW +: XW] = val_of(t);
                    fu_take_branch[i]    = t[0];
                    if (fu_ready[i]) begin
                        sb_tag[i].push_back(t);
                        sb_cap[i].push_back(it);
                        seq[i] = seq[i] + 4'd1;
                    end
                end else begin
                    fu_valid[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("hs_drain_unit%0d", i), 32'(sb_tag[i].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completed results from the execution units (ALU, branch, mult, load) onto the common data buses (CDBs) of the 2-way superscalar core. Each unit owns a one-entry holding register; up to `NUM_CDB` held results are broadcast per cycle, chosen round-robin. Units are back-pressured with a ready signal. A branch-mispredict squash flushes everything in flight.

## Interface
- `NUM_FU`, default 4: number of requesting functional units.
- `NUM_CDB`, default 2: number of CDB broadcast slots per cycle. Must satisfy 1 ≤ `NUM_CDB` ≤ `NUM_FU`.
- `TAG_W`, default 6: ROB tag width.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `squash` in 1: mispredict flush. Acts at the next edge.
- `fu_valid` in `NUM_FU`: unit i presents a result this cycle.
- `fu_tag` in `NUM_FU`×`TAG_W`: destination ROB tag per unit.
- `fu_value` in `NUM_FU`×`XLEN`: result value per unit.
- `fu_take_branch` in `NUM_FU`: resolved branch direction per unit.
- `fu_ready` out `NUM_FU`: unit i's result will be accepted at this edge.
- `cdb_valid` out `NUM_CDB`: slot k is broadcasting.
- `cdb_tag` out `NUM_CDB`×`TAG_W`: broadcast tag per slot.
- `cdb_value` out `NUM_CDB`×`XLEN`: broadcast value per slot.
- `cdb_take_branch` out `NUM_CDB`: broadcast branch flag per slot.

## Operation
- **State**
  - Per unit: `hold_valid[i]`, `hold_tag[i]`, `hold_value[i]`, `hold_tb[i]`.
  - One `rr_ptr` register, `clog2(NUM_FU)` bits wide.
- **Grant**
  - Computed only from registered state (`hold_valid`, `rr_ptr`). There is no combinational path from `fu_*` inputs to any output.
  - Scan indices `rr_ptr`, `rr_ptr+1`, … modulo `NUM_FU`.
  - The first `NUM_CDB` indices with `hold_valid` set are granted, in scan order.
  - The first granted index drives slot 0, the next drives slot 1, and so on.
- **CDB outputs**
  - Granted slots broadcast the holding-register contents.
  - Unused slots drive `cdb_valid`=0, and tag, value and take_branch all 0.
- **Ready**
  - `fu_ready[i] = ~hold_valid[i] | grant[i]`.
  - A unit may therefore hand over a new result in the same cycle its previous one is broadcast.
- **Capture**
  - At an edge where `fu_valid[i] & fu_ready[i] & ~squash`, load the holding register with `hold_valid[i]`=1.
  - Otherwise, if `grant[i]`, clear `hold_valid[i]`.
  - Units must hold `fu_*` stable while `fu_valid` is high and `fu_ready` is low.
- **Pointer**
  - If at least one grant is made, `rr_ptr` becomes (last granted index + 1) mod `NUM_FU`.
  - With no grant, `rr_ptr` is unchanged.
- **Squash**
  - At the edge, all `hold_valid` bits clear and `rr_ptr` is kept.
  - Results presented in the same cycle are dropped.
  - CDB outputs in the squash cycle itself still broadcast; the ROB and RS ignore them on squash.
- **Reset**
  - All `hold_valid`=0 and `rr_ptr`=0.
  - Consequently every `cdb_valid`=0 and every `fu_ready`=1 in the cycle after reset.
  - Reset mid-operation discards all held results.

## Timing
- **Latency:** a result accepted at edge N is broadcast in cycle N+1, at the earliest.
- **Throughput:** `NUM_CDB` results per cycle. Each unit can sustain 1 result per cycle while it keeps being granted.
- **Fairness:** a held result is broadcast within ceil(`NUM_FU`/`NUM_CDB`) cycles of capture. With the defaults that bound is 2 cycles.
- **Simultaneous grant and capture at one unit:** the old value is broadcast this cycle and the new value is held, with `hold_valid` staying 1.
- **Pointer wrap:** when the last grant is at index `NUM_FU`-1, `rr_ptr` wraps to 0.
- **Reset and squash together:** reset takes priority; both clear the same state.

## Structure
- Shared package `sys_defs`:
  - `CDB_PACKET` typedef: valid, tag, value, take_branch.
  - `NUM_CDB` and `NUM_FU` constants.
  - `ROB_TAG_W`.
  - The units' `FU_RS_PACKET` gains a ROB tag field.
- Sub-module `rr_select`:
  - Inputs: request vector and pointer.
  - Output: one-hot first request at or after the pointer, with wrap.
  - Instantiated `NUM_CDB` times, each instance masking off the grants already made by earlier instances.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `fu_valid`=4'b1111 → all `cdb_valid`=0 and `fu_ready`=4'b1111 during reset; `hold_valid` stays 0.
- **Single result:** unit 2 presents tag 5, value 0x1234 in one cycle → next cycle slot 0 broadcasts tag 5, value 0x1234; slot 1 is invalid; `rr_ptr` becomes 3.
- **Oversubscription:** all 4 units present tags 1–4 in one cycle with `rr_ptr`=0 → cycle+1 broadcasts tags 1 and 2; cycle+2 broadcasts tags 3 and 4; `fu_ready` for units 2 and 3 is low during cycle+1.
- **Back-to-back:** unit 0 presents a new result every cycle while being granted → `fu_ready[0]` stays 1 and slot 0 broadcasts every cycle with no bubbles.
- **Round-robin wrap:** `rr_ptr`=3, units 3 and 0 held → unit 3 is granted on slot 0 and unit 0 on slot 1; `rr_ptr` becomes 1.
- **Squash:** units 1 and 2 are held and unit 3 presents in the same cycle as `squash` → next cycle all `cdb_valid`=0, all `fu_ready`=1, and unit 3's tag is never broadcast.
